serial_mag_comparator: RTL

//  Parametrised, multi-cycle magnitude comparator: next generation of the 2-bit combinational compa.

---
 rtl/serial_mag_comparator_if.sv | 25 ++
 rtl/serial_mag_comparator.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_mag_comparator_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The requester drives start and operands; the comparator returns status and l/e/g.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             l;
  logic             e;
  logic             g;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, l, e, g
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, l, e, g
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle with early exit.
// Signed mode flips both MSBs (offset binary) so the unsigned digit compare yields the signed order.
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_mag_comparator_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             r_l;
  logic             r_e;
  logic             r_g;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_last;

  assign w_da   = r_sa[WIDTH-1 -: DIGIT];
  assign w_db   = r_sb[WIDTH-1 -: DIGIT];
  assign w_last = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if ((w_da != w_db) || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Control and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_l    <= 1'b0;
      r_e    <= 1'b0;
      r_g    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_l   <= 1'b0;
            r_e   <= 1'b0;
            r_g   <= 1'b0;
            r_cnt <= CW'(N - 1);
          end
        end
        S_RUN: begin
          if (w_da > w_db) begin
            r_g    <= 1'b1;
            r_done <= 1'b1;
          end else if (w_da < w_db) begin
            r_l    <= 1'b1;
            r_done <= 1'b1;
          end else if (w_last) begin
            r_e    <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  // Operand shift registers carry no reset; they are reloaded on every accepted start
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.start) begin
      r_sa <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
      r_sb <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
    end else if ((r_state == S_RUN) && (w_da == w_db) && !w_last) begin
      r_sa <= r_sa << DIGIT;
      r_sb <= r_sb << DIGIT;
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = r_done;
  assign bus.l    = r_l;
  assign bus.e    = r_e;
  assign bus.g    = r_g;
endmodule
